instr_encoder: RTL and testbench
================================

# instr_encoder

Program-loader back end that encodes symbolic MIPS commands into 32-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the opcode/funct decoder in the Control path: a host (debug UART, test sequencer) issues one command per valid/ready handshake, and the block emits the matching opcode/funct encoding. It also expands the LI pseudo-instruction into the two-word sequence LUI followed by ORI.

## Interface
- ADDR_WIDTH, 8: word-address width of the target instruction memory; DEPTH = 2^ADDR_WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  5  command code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLL, 6 SRL, 7 JR, 8 ADDI, 9 ORI, 10 ANDI, 11 LUI, 12 LW, 13 SW, 14 BEQ, 15 BNE, 16 J, 17 JAL, 18 LI, 19 NOP. Codes 20–31 are illegal.
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register and shift fields.
- cmd_imm  in  32  [15:0] is the I-type immediate, [25:0] is the J target, and [31:0] is the LI constant.
- flush  in  1  clears the write pointer, err and full. Honoured only in IDLE.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address of the current write.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  state is not IDLE.
- err  out  1  sticky flag for an illegal op or an LI that does not fit.
- full  out  1  word_count == DEPTH.
- word_count  out  ADDR_WIDTH+1  number of words written since reset or flush.

## Operation
- **FSM states:** IDLE, EMIT, EMIT_LO.
- **Accept:** a command is accepted when cmd_valid && cmd_ready. cmd_ready = reset && state==IDLE && !full. All command fields are captured on acceptance.
- **IDLE → EMIT** on accept of a legal op. This covers every legal op except an LI that does not fit (see below).
- **Illegal op:** on accept of an illegal op, set err and stay in IDLE. No write occurs.
- **LI overflow:** LI accepted while word_count == DEPTH-1 sets err and causes no write, so no half pseudo-instruction is ever written.
- **EMIT:** mem_we=1, mem_addr=ptr, mem_wdata=word, ptr++. The next state is EMIT_LO for LI and IDLE for every other op.
- **EMIT_LO:** writes the ORI half, ptr++, then returns to IDLE.
- **R-type encoding:** {6'h00, rs, rt, rd, shamt, funct}.
  - funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLL 0x00, SRL 0x02, JR 0x08.
  - shamt is forced to 0 except for SLL/SRL.
  - rs is forced to 0 for SLL/SRL.
  - rt, rd and shamt are forced to 0 for JR.
- **I-type encoding:** {op6, rs, rt, imm[15:0]}.
  - op6 values: ADDI 0x08, ORI 0x0D, ANDI 0x0C, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - rs is forced to 0 for LUI.
- **J-type encoding:** {op6, imm[25:0]}, with J 0x02 and JAL 0x03.
- **LI expansion:** LUI {0x0F, 0, rt, imm[31:16]}, then ORI {0x0D, rt, rt, imm[15:0]}.
- **NOP** writes 32'h00000000.
- **No wrap-around:** ptr saturates at DEPTH. Once full, cmd_ready stays low until flush.
- **Flush:** flush in IDLE clears ptr, err and full on the next edge. If cmd_valid and flush are both high in IDLE, flush wins and the command is not accepted (cmd_ready is low that cycle). flush outside IDLE is ignored.

## Timing
- **Registered outputs:** mem_we, mem_addr, mem_wdata, err, full and word_count are registered. cmd_ready and busy are combinational from state.
- **Reset values:** mem_we=0, mem_addr=0, mem_wdata=0, err=0, full=0, word_count=0, busy=0, state=IDLE. cmd_ready=0 while reset is low.
- **Latency:** mem_we is high during the cycle after acceptance.
  - Single-word commands: one write; cmd_ready is low for 1 cycle, so peak throughput is 1 command per 2 cycles.
  - LI: two consecutive write cycles; cmd_ready is low for 2 cycles.
- **Reset mid-operation:** reset asserted mid-LI (after the LUI write) abandons the ORI half. All state returns to reset values immediately, without waiting for a clock edge.
- **Count update:** word_count increments in the same cycle that mem_we is asserted.

## Structure
- **Shared package/include `mips_isa_defs`:** holds the opcode and funct localparams (shared with the control decoder), the 5-bit command-code constants, and the FSM state encodings.
- **Sub-module `instr_word_builder`:** combinational; maps (op, fields, lo_phase) to {word, legal}. The FSM in instr_encoder instantiates it once.

## Test plan
1. **ADD encoding:** after reset, ADD rs=9 rt=10 rd=8 → one cycle later mem_we=1, addr 0, data 0x012A4020; word_count=1.
2. **ADDI encoding:** ADDI rs=0 rt=8 imm=0x0005 → addr 1, data 0x20080005. JAL imm=0x0100000 → addr 2, data 0x0C100000.
3. **LI expansion:** LI rt=9 imm=0x1234ABCD → back-to-back writes 0x3C091234 then 0x3529ABCD; cmd_ready low for exactly 2 cycles.
4. **Illegal op and flush:** illegal op 25 → no mem_we, err=1, word_count unchanged. Then flush in IDLE → err=0, word_count=0, and the next write goes to addr 0.
5. **Full and LI overflow (ADDR_WIDTH=2):**
   - Four writes → full=1, cmd_ready=0, and no further writes occur.
   - After flush and three writes, LI → err=1 and no write.
6. **Reset mid-LI:** assert reset in the cycle after the LUI write → every output is 0 and no ORI write occurs. After reset release, cmd_ready=1 and word_count=0.

Source files
------------

// File: rtl/mips_isa_defs_pkg.sv
// mips_isa_defs: MIPS opcode and funct encodings (shared with the control
// decoder), the 5-bit host command codes accepted by instr_encoder, and the
// encoder FSM state type.
package mips_isa_defs;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // Host command codes; 20..31 are illegal
    localparam logic [4:0] CMD_ADD  = 5'd0;
    localparam logic [4:0] CMD_SUB  = 5'd1;
    localparam logic [4:0] CMD_AND  = 5'd2;
    localparam logic [4:0] CMD_OR   = 5'd3;
    localparam logic [4:0] CMD_NOR  = 5'd4;
    localparam logic [4:0] CMD_SLL  = 5'd5;
    localparam logic [4:0] CMD_SRL  = 5'd6;
    localparam logic [4:0] CMD_JR   = 5'd7;
    localparam logic [4:0] CMD_ADDI = 5'd8;
    localparam logic [4:0] CMD_ORI  = 5'd9;
    localparam logic [4:0] CMD_ANDI = 5'd10;
    localparam logic [4:0] CMD_LUI  = 5'd11;
    localparam logic [4:0] CMD_LW   = 5'd12;
    localparam logic [4:0] CMD_SW   = 5'd13;
    localparam logic [4:0] CMD_BEQ  = 5'd14;
    localparam logic [4:0] CMD_BNE  = 5'd15;
    localparam logic [4:0] CMD_J    = 5'd16;
    localparam logic [4:0] CMD_JAL  = 5'd17;
    localparam logic [4:0] CMD_LI   = 5'd18;
    localparam logic [4:0] CMD_NOP  = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_EMIT_LO = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_word_builder.sv
// instr_word_builder: combinational map from a host command to a 32-bit MIPS
// instruction word.
// Ports: op/rs/rt/rd/shamt/imm - command fields; lo_phase - selects the ORI
// half of an LI expansion (LUI half otherwise); word - encoded instruction;
// legal - op is a defined command code.
module instr_word_builder
    import mips_isa_defs::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic        lo_phase,
    output logic [31:0] word,
    output logic        legal
);

    // Encode the command; unused fields are forced to zero per instruction form
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (op)
            CMD_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            CMD_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            CMD_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            CMD_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            CMD_NOR:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
            CMD_SLL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
            CMD_SRL:  word = {OP_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
            CMD_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            CMD_ADDI: word = {OP_ADDI, rs, rt, imm[15:0]};
            CMD_ORI:  word = {OP_ORI, rs, rt, imm[15:0]};
            CMD_ANDI: word = {OP_ANDI, rs, rt, imm[15:0]};
            CMD_LUI:  word = {OP_LUI, 5'd0, rt, imm[15:0]};
            CMD_LW:   word = {OP_LW, rs, rt, imm[15:0]};
            CMD_SW:   word = {OP_SW, rs, rt, imm[15:0]};
            CMD_BEQ:  word = {OP_BEQ, rs, rt, imm[15:0]};
            CMD_BNE:  word = {OP_BNE, rs, rt, imm[15:0]};
            CMD_J:    word = {OP_J, imm[25:0]};
            CMD_JAL:  word = {OP_JAL, imm[25:0]};
            CMD_LI: begin
                // LI rt, K  ->  LUI rt, K[31:16] ; ORI rt, rt, K[15:0]
                if (lo_phase) begin
                    word = {OP_ORI, rt, rt, imm[15:0]};
                end else begin
                    word = {OP_LUI, 5'd0, rt, imm[31:16]};
                end
            end
            CMD_NOP:  word = 32'h0000_0000;
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic MIPS commands over a valid/ready handshake
// and writes the encoded instruction words sequentially into instruction
// memory, expanding LI into LUI+ORI.
// Ports: clk, reset (async, active-low); cmd_valid/cmd_ready handshake with
// cmd_op/rs/rt/rd/shamt/imm fields; flush (idle-only clear of pointer, err,
// full); mem_we/mem_addr/mem_wdata memory write port; busy, err (sticky),
// full, word_count status.
module instr_encoder
    import mips_isa_defs::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_op,
    input  logic [4:0]            cmd_rs,
    input  logic [4:0]            cmd_rt,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_shamt,
    input  logic [31:0]           cmd_imm,
    input  logic                  flush,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  err,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_V  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE_V   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    enc_state_e            state_r, state_n;
    logic [4:0]            op_r, rs_r, rt_r, rd_r, shamt_r;
    logic [31:0]           imm_r;
    logic [ADDR_WIDTH:0]   ptr_r, ptr_n, ptr_inc_s;
    logic                  we_r, we_n;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n;
    logic [31:0]           wdata_r, wdata_n;
    logic                  err_r, err_n;
    logic                  full_r, full_n;

    logic [4:0]            sel_op_s, sel_rs_s, sel_rt_s, sel_rd_s, sel_shamt_s;
    logic [31:0]           sel_imm_s;
    logic                  lo_phase_s;
    logic [31:0]           word_s;
    logic                  legal_s;
    logic                  idle_s;
    logic                  accept_s;

    assign idle_s    = (state_r == ST_IDLE);
    // flush has priority over a command in the same cycle
    assign cmd_ready = reset && idle_s && !full_r && !flush;
    // reset is left out here: every flop is held in reset while it is low
    assign accept_s  = cmd_valid && idle_s && !full_r && !flush;
    assign ptr_inc_s = ptr_r + ONE_V;
    // In EMIT the builder prepares the second (ORI) half of an LI
    assign lo_phase_s = (state_r == ST_EMIT);

    // Builder sees the live command in IDLE and the captured one afterwards
    always_comb begin
        sel_op_s    = op_r;
        sel_rs_s    = rs_r;
        sel_rt_s    = rt_r;
        sel_rd_s    = rd_r;
        sel_shamt_s = shamt_r;
        sel_imm_s   = imm_r;
        if (idle_s) begin
            sel_op_s    = cmd_op;
            sel_rs_s    = cmd_rs;
            sel_rt_s    = cmd_rt;
            sel_rd_s    = cmd_rd;
            sel_shamt_s = cmd_shamt;
            sel_imm_s   = cmd_imm;
        end else begin
            sel_op_s    = op_r;
        end
    end

    instr_word_builder u_builder (
        .op       (sel_op_s),
        .rs       (sel_rs_s),
        .rt       (sel_rt_s),
        .rd       (sel_rd_s),
        .shamt    (sel_shamt_s),
        .imm      (sel_imm_s),
        .lo_phase (lo_phase_s),
        .word     (word_s),
        .legal    (legal_s)
    );

    // Next-state, write strobe, pointer and status computation
    always_comb begin
        state_n = state_r;
        we_n    = 1'b0;
        addr_n  = addr_r;
        wdata_n = wdata_r;
        ptr_n   = ptr_r;
        err_n   = err_r;
        full_n  = full_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    ptr_n  = {(ADDR_WIDTH+1){1'b0}};
                    err_n  = 1'b0;
                    full_n = 1'b0;
                end else if (accept_s) begin
                    if (!legal_s) begin
                        err_n = 1'b1;
                    end else if ((cmd_op == CMD_LI) && (ptr_r == LAST_V)) begin
                        // Only one slot left: refuse rather than write half an LI
                        err_n = 1'b1;
                    end else begin
                        we_n    = 1'b1;
                        addr_n  = ptr_r[ADDR_WIDTH-1:0];
                        wdata_n = word_s;
                        ptr_n   = ptr_inc_s;
                        full_n  = (ptr_inc_s == DEPTH_V);
                        state_n = ST_EMIT;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (op_r == CMD_LI) begin
                    we_n    = 1'b1;
                    addr_n  = ptr_r[ADDR_WIDTH-1:0];
                    wdata_n = word_s;
                    ptr_n   = ptr_inc_s;
                    full_n  = (ptr_inc_s == DEPTH_V);
                    state_n = ST_EMIT_LO;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_EMIT_LO: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Command field capture on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r    <= 5'd0;
            rs_r    <= 5'd0;
            rt_r    <= 5'd0;
            rd_r    <= 5'd0;
            shamt_r <= 5'd0;
            imm_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            op_r    <= cmd_op;
            rs_r    <= cmd_rs;
            rt_r    <= cmd_rt;
            rd_r    <= cmd_rd;
            shamt_r <= cmd_shamt;
            imm_r   <= cmd_imm;
        end
    end

    // State and registered output update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 32'h0000_0000;
            ptr_r   <= {(ADDR_WIDTH+1){1'b0}};
            err_r   <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            we_r    <= we_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
            ptr_r   <= ptr_n;
            err_r   <= err_n;
            full_r  <= full_n;
        end
    end

    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign err        = err_r;
    assign full       = full_r;
    assign word_count = ptr_r;
    assign busy       = !idle_s;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with a 4-word memory.
// Stimulus pushes expected writes from a reference model; a monitor pops and
// compares whenever mem_we is seen.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int R_FUNCT [8] = '{32, 34, 36, 37, 39, 0, 2, 8};
    localparam int I_OPC   [8] = '{8, 13, 12, 15, 35, 43, 4, 5};

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_op = 5'd0, cmd_rs = 5'd0, cmd_rt = 5'd0;
    logic [4:0]    cmd_rd = 5'd0, cmd_shamt = 5'd0;
    logic [31:0]   cmd_imm = 32'h0;
    logic          flush = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, err, full;
    logic [AW:0]   word_count;

    exp_t        q[$];
    logic [31:0] obs_data[$];
    int          obs_addr[$];
    int          ref_cnt = 0;
    bit          ref_err = 1'b0;
    int          total = 0;
    int          bad = 0;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .flush(flush),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .err(err), .full(full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: instruction words for a command, from the ISA field layout
    function automatic void ref_encode(input int op, input int rs, input int rt,
                                       input int rd, input int sh, input logic [31:0] imm,
                                       output int n, output logic [31:0] w0, output logic [31:0] w1);
        longint v;
        longint lo16;
        longint hi16;
        lo16 = longint'(imm) % 65536;
        hi16 = longint'(imm) / 65536;
        n  = 1;
        w0 = 32'h0;
        w1 = 32'h0;
        if (op <= 7) begin
            int rs_e, rt_e, rd_e, sh_e;
            rs_e = (op == 5 || op == 6) ? 0 : rs;
            rt_e = (op == 7) ? 0 : rt;
            rd_e = (op == 7) ? 0 : rd;
            sh_e = (op == 5 || op == 6) ? sh : 0;
            v = longint'(rs_e) * (1 << 21) + longint'(rt_e) * (1 << 16)
              + longint'(rd_e) * (1 << 11) + longint'(sh_e) * 64 + longint'(R_FUNCT[op]);
            w0 = 32'(v);
        end else if (op <= 15) begin
            v = longint'(I_OPC[op-8]) * (1 << 26) + longint'((op == 11) ? 0 : rs) * (1 << 21)
              + longint'(rt) * (1 << 16) + lo16;
            w0 = 32'(v);
        end else if (op <= 17) begin
            v = longint'(op - 14) * (1 << 26) + (longint'(imm) % (1 << 26));
            w0 = 32'(v);
        end else if (op == 18) begin
            n  = 2;
            w0 = 32'(longint'(15) * (1 << 26) + longint'(rt) * (1 << 16) + hi16);
            w1 = 32'(longint'(13) * (1 << 26) + longint'(rt) * (1 << 21)
                   + longint'(rt) * (1 << 16) + lo16);
        end else if (op == 19) begin
            w0 = 32'h0;
        end else begin
            n = 0;
        end
    endfunction

    // Model the effect of an accepted command; returns the number of words written
    task automatic model_accept(input int op, input int rs, input int rt, input int rd,
                                input int sh, input logic [31:0] imm, output int n);
        logic [31:0] w0, w1;
        exp_t e;
        ref_encode(op, rs, rt, rd, sh, imm, n, w0, w1);
        if (n == 0 || (n == 2 && ref_cnt == DEPTH - 1)) begin
            ref_err = 1'b1;
            n = 0;
        end
        for (int k = 0; k < n; k++) begin
            e.addr = ref_cnt;
            e.data = (k == 0) ? w0 : w1;
            e.cnt  = ref_cnt + 1;
            q.push_back(e);
            ref_cnt++;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ref_err});
        chk({tag, "_full"}, {31'd0, full}, {31'd0, ref_cnt == DEPTH});
        chk({tag, "_count"}, 32'(word_count), 32'(ref_cnt));
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic drive(input int op, input int rs, input int rt, input int rd,
                         input int sh, input logic [31:0] imm);
        cmd_op    = 5'(op);
        cmd_rs    = 5'(rs);
        cmd_rt    = 5'(rt);
        cmd_rd    = 5'(rd);
        cmd_shamt = 5'(sh);
        cmd_imm   = imm;
        cmd_valid = 1'b1;
    endtask

    task automatic issue(input int op, input int rs, input int rt, input int rd,
                         input int sh, input logic [31:0] imm);
        int waited = 0;
        int n;
        int low = 0;
        int exp_low;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
            return;
        end
        drive(op, rs, rt, rd, sh, imm);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_accept(op, rs, rt, rd, sh, imm, n);
        exp_low = (ref_cnt == DEPTH) ? 5 : n;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
            low++;
        end
        chk("ready_low_cycles", 32'(low), 32'(exp_low));
        check_status("post_cmd");
    endtask

    task automatic do_flush(input bit with_cmd);
        @(negedge clk);
        flush = 1'b1;
        if (with_cmd) drive(0, 1, 2, 3, 0, 32'h0);
        #1 chk("ready_during_flush", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        ref_cnt   = 0;
        ref_err   = 1'b0;
        @(negedge clk);
        check_status("post_flush");
    endtask

    // Monitor: every observed write must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
                chk("wr_count", 32'(word_count), 32'(e.cnt));
            end
            obs_data.push_back(mem_wdata);
            obs_addr.push_back(int'(mem_addr));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_status("rst");
        reset = 1'b1;

        // ADD / ADDI / JAL encodings
        obs_data.delete();
        obs_addr.delete();
        issue(0, 9, 10, 8, 0, 32'h0);
        issue(8, 0, 8, 0, 0, 32'h0000_0005);
        issue(17, 0, 0, 0, 0, 32'h0010_0000);
        chk("add_word", obs_data[0], 32'h012A_4020);
        chk("addi_word", obs_data[1], 32'h2008_0005);
        chk("addi_addr", 32'(obs_addr[1]), 32'd1);
        chk("jal_word", obs_data[2], 32'h0C10_0000);
        chk("jal_addr", 32'(obs_addr[2]), 32'd2);

        // LI expansion
        do_flush(1'b1);
        obs_data.delete();
        issue(18, 0, 9, 0, 0, 32'h1234_ABCD);
        chk("li_lui", obs_data[0], 32'h3C09_1234);
        chk("li_ori", obs_data[1], 32'h3529_ABCD);

        // Illegal op, then flush restarts at address 0
        issue(25, 1, 2, 3, 4, 32'hFFFF_FFFF);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_count", 32'(word_count), 32'd2);
        do_flush(1'b0);
        obs_addr.delete();
        issue(3, 4, 5, 6, 0, 32'h0);
        chk("after_flush_addr", 32'(obs_addr[0]), 32'd0);

        // Fill to full; a waiting command must not be taken
        issue(19, 0, 0, 0, 0, 32'h0);
        issue(13, 29, 31, 0, 0, 32'h0000_FFFC);
        issue(6, 7, 8, 9, 31, 32'h0);
        chk("full_flag", {31'd0, full}, 32'd1);
        @(negedge clk);
        drive(1, 1, 1, 1, 0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;

        // LI with one slot left
        do_flush(1'b0);
        for (int i = 0; i < 3; i++) issue(8, i, i + 1, 0, 0, 32'(i * 3));
        issue(18, 0, 5, 0, 0, 32'hDEAD_BEEF);
        chk("li_ovf_err", {31'd0, err}, 32'd1);
        chk("li_ovf_count", 32'(word_count), 32'd3);

        // Reset in the cycle after the LUI write
        do_flush(1'b0);
        @(negedge clk);
        drive(18, 0, 9, 0, 0, 32'h1234_ABCD);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_accept(18, 0, 9, 0, 0, 32'h1234_ABCD, n);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        q.delete();
        ref_cnt = 0;
        ref_err = 1'b0;
        check_status("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_ori", {31'd0, mem_we}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rel_count", 32'(word_count), 32'd0);
        chk("rel_we", {31'd0, mem_we}, 32'd0);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            if (ref_cnt == DEPTH || $urandom_range(0, 9) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                int op;
                op = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 19) : $urandom_range(20, 31);
                issue(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
